sram_access_arbiter: RTL and testbench



---
 rtl/sram_access_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
//
// Shares one single-port SRAM macro between a write requester and a read
// requester. At most one access is granted per cycle; the granted access is
// registered onto the SRAM pins the following cycle. Read data returns at a
// fixed latency of RD_LAT cycles after the grant. A saturating starve counter
// bounds how many consecutive writes may win while a read is waiting. A flush
// handshake stops granting, drains in-flight reads and then reports idle.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   wr_req/wr_addr/wr_data    write request, held stable until wr_gnt
//   wr_gnt                    combinational write accept
//   rd_req/rd_addr            read request, held stable until rd_gnt
//   rd_gnt                    combinational read accept
//   rd_valid/rd_data          registered read return, one cycle per read
//   flush                     level request to quiesce
//   flush_done                registered, high while drained under flush
//   sram_cen/sram_wen         registered active-low chip/write enables
//   sram_a/sram_d             registered address and write data
//   sram_q                    SRAM read data, valid one cycle after access

module sram_access_arbiter #(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned DATA_W     = 256,
   parameter int unsigned RD_LAT     = 3,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              flush,
   output logic              flush_done,
   output logic              sram_cen,
   output logic              sram_wen,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_d,
   input  logic [DATA_W-1:0] sram_q
);

   // Starve counter must hold STARVE_LIM itself.
   localparam int unsigned CNT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
   localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIM);

   // Data stages after the SRAM: one capture stage plus RD_LAT-3 delay stages.
   localparam int unsigned DP = RD_LAT - 2;

   localparam logic [1:0] StRun     = 2'd0;
   localparam logic [1:0] StDrain   = 2'd1;
   localparam logic [1:0] StFlushed = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [DATA_W-1:0] dpipe_q [DP];
   logic              flush_done_q;

   logic              cen_q, cen_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] d_q, d_d;

   // ------------------------------------------------------------------
   // Arbitration: only while running and not being asked to flush.
   // Writes win unless no write is waiting or the read has starved.
   // ------------------------------------------------------------------
   always_comb begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
      if (!rst && (state_q == StRun) && !flush) begin
         if (rd_req && (!wr_req || (starve_q == StarveMax))) begin
            rd_gnt = 1'b1;
         end else if (wr_req) begin
            wr_gnt = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Starve counter
   // ------------------------------------------------------------------
   always_comb begin
      starve_d = starve_q;
      if (rd_gnt || !rd_req) begin
         starve_d = '0;
      end else if (wr_gnt && (starve_q != StarveMax)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Read-valid shift register: bit k set means a read granted k+1
   // cycles ago is still in flight.
   // ------------------------------------------------------------------
   assign vld_d = {vld_q[RD_LAT-2:0], rd_gnt};

   // ------------------------------------------------------------------
   // Flush FSM. DRAIN looks at the next-cycle valid vector so that
   // flush_done rises the cycle right after the last rd_valid.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun: begin
            if (flush) state_d = StDrain;
         end
         StDrain: begin
            if (!flush) begin
               state_d = StRun;
            end else if (vld_d == '0) begin
               state_d = StFlushed;
            end
         end
         StFlushed: begin
            if (!flush) state_d = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   // ------------------------------------------------------------------
   // SRAM pin next-state. Address holds when idle; write data is zero
   // unless a write is being issued.
   // ------------------------------------------------------------------
   always_comb begin
      cen_d = 1'b1;
      wen_d = 1'b1;
      a_d   = a_q;
      d_d   = '0;
      if (wr_gnt) begin
         cen_d = 1'b0;
         wen_d = 1'b0;
         a_d   = wr_addr;
         d_d   = wr_data;
      end else if (rd_gnt) begin
         cen_d = 1'b0;
         a_d   = rd_addr;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StRun;
         starve_q     <= '0;
         vld_q        <= '0;
         flush_done_q <= 1'b0;
         cen_q        <= 1'b1;
         wen_q        <= 1'b1;
         a_q          <= '0;
         d_q          <= '0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         vld_q        <= vld_d;
         flush_done_q <= (state_d == StFlushed);
         cen_q        <= cen_d;
         wen_q        <= wen_d;
         a_q          <= a_d;
         d_q          <= d_d;
      end
   end

   // Read data path. sram_q holds the word while vld_q[1] is set (access
   // on the pins the cycle before); gating here keeps rd_data zero between
   // results and the later stages simply shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DP; i++) begin
            dpipe_q[i] <= '0;
         end
      end else begin
         dpipe_q[0] <= vld_q[1] ? sram_q : '0;
         for (int i = 1; i < DP; i++) begin
            dpipe_q[i] <= dpipe_q[i-1];
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign rd_valid   = vld_q[RD_LAT-1];
   assign rd_data    = dpipe_q[DP-1];
   assign flush_done = flush_done_q;
   assign sram_cen   = cen_q;
   assign sram_wen   = wen_q;
   assign sram_a     = a_q;
   assign sram_d     = d_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Testbench for sram_access_arbiter: directed scenarios followed by a
// randomized phase, all checked cycle by cycle against a reference model
// built from grant-order memory updates and a queue of due read results.

module tb_sram_access_arbiter;

   localparam int unsigned ADDR_W     = 10;
   localparam int unsigned DATA_W     = 256;
   localparam int unsigned RD_LAT     = 3;
   localparam int unsigned STARVE_LIM = 4;
   localparam int unsigned NADDR      = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_gnt;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_gnt;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              flush;
   logic              flush_done;
   logic              sram_cen;
   logic              sram_wen;
   logic [ADDR_W-1:0] sram_a;
   logic [DATA_W-1:0] sram_d;
   logic [DATA_W-1:0] sram_q = '0;

   always #5 clk = ~clk;

   sram_access_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .RD_LAT    (RD_LAT),
      .STARVE_LIM(STARVE_LIM)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_gnt    (wr_gnt),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_gnt    (rd_gnt),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .flush     (flush),
      .flush_done(flush_done),
      .sram_cen  (sram_cen),
      .sram_wen  (sram_wen),
      .sram_a    (sram_a),
      .sram_d    (sram_d),
      .sram_q    (sram_q)
   );

   // Single-port SRAM macro: acts on the pins at the rising edge.
   logic [DATA_W-1:0] sram_mem [1 << ADDR_W];
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_wen) sram_mem[sram_a] <= sram_d;
         else           sram_q <= sram_mem[sram_a];
      end
   end

   // ---------------- reference model ----------------
   typedef enum int {MRun, MDrain, MFlushed} mode_t;
   typedef struct {
      int                due;
      logic [DATA_W-1:0] data;
   } rd_ret_t;

   logic [DATA_W-1:0] ref_mem [NADDR];
   rd_ret_t           rq[$];
   mode_t             mode;
   int                starve;
   int                cyc;
   logic              e_cen, e_wen, e_fd;
   logic [ADDR_W-1:0] e_a;
   logic [DATA_W-1:0] e_d;
   logic              m_wg, m_rg;   // model grants in the last cycle
   logic              d_rg;         // DUT read grant in the last cycle

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      rq.delete();
      mode   = MRun;
      starve = 0;
      e_cen  = 1'b1;
      e_wen  = 1'b1;
      e_a    = '0;
      e_d    = '0;
      e_fd   = 1'b0;
   endtask

   // One clock cycle: inputs are already stable; compare at the falling edge,
   // advance the model, then return just after the next rising edge.
   task automatic cycle();
      logic              ew, er, ev;
      logic [DATA_W-1:0] ed;
      @(negedge clk);
      ew = 1'b0;
      er = 1'b0;
      if (!rst && mode == MRun && !flush) begin
         if (rd_req && (!wr_req || starve == int'(STARVE_LIM))) er = 1'b1;
         else if (wr_req) ew = 1'b1;
      end
      ev = (rq.size() > 0) && (rq[0].due == cyc);
      ed = ev ? rq[0].data : '0;
      if (ev) void'(rq.pop_front());

      chk("wr_gnt", DATA_W'(wr_gnt), DATA_W'(ew));
      chk("rd_gnt", DATA_W'(rd_gnt), DATA_W'(er));
      chk("sram_cen", DATA_W'(sram_cen), DATA_W'(e_cen));
      chk("sram_wen", DATA_W'(sram_wen), DATA_W'(e_wen));
      chk("sram_a", DATA_W'(sram_a), DATA_W'(e_a));
      chk("sram_d", sram_d, e_d);
      chk("rd_valid", DATA_W'(rd_valid), DATA_W'(ev));
      chk("rd_data", rd_data, ed);
      chk("flush_done", DATA_W'(flush_done), DATA_W'(e_fd));
      d_rg = rd_gnt;

      if (rst) begin
         model_reset();
      end else begin
         e_cen = 1'b1;
         e_wen = 1'b1;
         e_d   = '0;
         if (ew) begin
            e_cen = 1'b0;
            e_wen = 1'b0;
            e_a   = wr_addr;
            e_d   = wr_data;
            ref_mem[wr_addr] = wr_data;
         end else if (er) begin
            e_cen = 1'b0;
            e_a   = rd_addr;
            rq.push_back('{due: cyc + int'(RD_LAT), data: ref_mem[rd_addr]});
         end
         if (er || !rd_req) starve = 0;
         else if (ew && starve < int'(STARVE_LIM)) starve++;
         case (mode)
            MRun:     if (flush) mode = MDrain;
            MDrain:   if (!flush) mode = MRun;
                      else if (rq.size() == 0) mode = MFlushed;
            MFlushed: if (!flush) mode = MRun;
            default:  mode = MRun;
         endcase
         e_fd = (mode == MFlushed);
      end
      m_wg = ew;
      m_rg = er;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      logic [DATA_W-1:0] w;
      for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // ---------------- stimulus ----------------
   int start;
   int gnt_at;

   initial begin
      rst     = 1'b1;
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_req  = 1'b0;
      rd_addr = '0;
      flush   = 1'b0;
      cyc     = 0;
      m_wg    = 1'b0;
      m_rg    = 1'b0;
      d_rg    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      cycle();                   // reset values on all registered outputs
      rst = 1'b0;

      // Preload addresses 0..NADDR-1 through the arbiter.
      for (int i = 0; i < int'(NADDR); i++) begin
         wr_req  = 1'b1;
         wr_addr = ADDR_W'(i);
         if (i == 5)      wr_data = {32{8'hA5}};
         else if (i < 4)  wr_data = DATA_W'(32'h100 + i);
         else             wr_data = rand_word();
         cycle();
      end
      wr_req = 1'b0;
      repeat (2) cycle();

      // Single read of address 5.
      rd_req  = 1'b1;
      rd_addr = ADDR_W'(5);
      cycle();
      rd_req = 1'b0;
      repeat (5) cycle();

      // Simultaneous write/read to address 7: read must win on the fifth cycle.
      wr_req  = 1'b1;
      wr_addr = ADDR_W'(7);
      wr_data = DATA_W'(1);
      rd_req  = 1'b1;
      rd_addr = ADDR_W'(7);
      start   = cyc;
      gnt_at  = -1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (d_rg) begin
            gnt_at = cyc - 1 - start;
            break;
         end
      end
      chk("starve_rd_gnt_cycle", DATA_W'(gnt_at), DATA_W'(STARVE_LIM));
      wr_req = 1'b0;
      rd_req = 1'b0;
      repeat (5) cycle();

      // Back-to-back reads of addresses 0..3.
      for (int i = 0; i < 4; i++) begin
         rd_req  = 1'b1;
         rd_addr = ADDR_W'(i);
         cycle();
      end
      rd_req = 1'b0;
      repeat (5) cycle();

      // Write 0xFF to address 9, then read it the next cycle.
      wr_req  = 1'b1;
      wr_addr = ADDR_W'(9);
      wr_data = DATA_W'(8'hFF);
      cycle();
      wr_req  = 1'b0;
      rd_req  = 1'b1;
      rd_addr = ADDR_W'(9);
      cycle();
      rd_req = 1'b0;
      repeat (5) cycle();

      // Flush with two reads in flight; a third read waits through the flush.
      rd_req  = 1'b1;
      rd_addr = ADDR_W'(10);
      cycle();
      rd_addr = ADDR_W'(11);
      cycle();
      rd_addr = ADDR_W'(12);
      flush   = 1'b1;
      repeat (6) cycle();
      chk("flush_done_held", DATA_W'(flush_done), DATA_W'(1));
      flush  = 1'b0;
      gnt_at = -1;
      start  = cyc;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (d_rg) begin
            gnt_at = cyc - 1 - start;
            break;
         end
      end
      chk("resume_after_flush", DATA_W'(gnt_at), DATA_W'(1));
      rd_req = 1'b0;
      repeat (5) cycle();

      // Reset with two reads in flight.
      rd_req  = 1'b1;
      rd_addr = ADDR_W'(2);
      cycle();
      rd_addr = ADDR_W'(3);
      cycle();
      rd_req = 1'b0;
      rst    = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (6) cycle();

      // Randomized traffic with occasional flush toggles and resets.
      for (int n = 0; n < 800; n++) begin
         if (!wr_req && ($urandom_range(2) == 0)) begin
            wr_req  = 1'b1;
            wr_addr = ADDR_W'($urandom_range(NADDR - 1));
            wr_data = rand_word();
         end
         if (!rd_req && ($urandom_range(1) == 0)) begin
            rd_req  = 1'b1;
            rd_addr = ADDR_W'($urandom_range(NADDR - 1));
         end
         if ($urandom_range(29) == 0) flush = ~flush;
         rst = ($urandom_range(199) == 0);
         cycle();
         if (m_wg || rst) wr_req = 1'b0;
         if (m_rg || rst) rd_req = 1'b0;
      end
      rst    = 1'b0;
      flush  = 1'b0;
      wr_req = 1'b0;
      rd_req = 1'b0;
      repeat (8) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
